// File: rtl/bram_job_sequencer.sv
// Job queue and run sequencer in front of the BRAM accessor: buffers host jobs,
// launches them one at a time, counts completions and recovers from hung runs.
module bram_job_sequencer #(
    parameter int CNT_BIT  = 31,
    parameter int QDEPTH   = 4,
    parameter int QLVL_W   = 3,
    parameter int TO_WIDTH = 16,
    parameter int JOBS_W   = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                job_valid_i,
    input  logic [CNT_BIT-1:0]  job_count_i,
    output logic                job_ready_o,
    input  logic                abort_i,
    input  logic [TO_WIDTH-1:0] timeout_i,
    input  logic                acc_idle_i,
    input  logic                acc_done_i,
    output logic                acc_start_o,
    output logic [CNT_BIT-1:0]  acc_count_o,
    output logic                busy_o,
    output logic [QLVL_W-1:0]   q_level_o,
    output logic [JOBS_W-1:0]   jobs_done_o,
    output logic                err_timeout_o,
    output logic                irq_o
);

    localparam int IDX_W = QLVL_W - 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [CNT_BIT-1:0]    mem_r [QDEPTH];
    logic [QLVL_W-1:0]     wr_ptr_r;
    logic [QLVL_W-1:0]     rd_ptr_r;
    logic [QLVL_W-1:0]     level_s;
    logic                  empty_s;
    logic                  full_s;
    logic [CNT_BIT-1:0]    head_s;
    logic                  pop_ok_s;
    logic                  ready_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  done_inc_s;
    logic                  start_nxt_s;
    logic                  irq_nxt_s;
    logic                  err_set_s;
    logic                  to_clr_s;
    logic                  to_inc_s;
    logic                  to_hit_s;
    logic [TO_WIDTH:0]     to_next_s;
    logic [TO_WIDTH-1:0]   to_cnt_r;
    logic [CNT_BIT-1:0]    count_r;
    logic [JOBS_W-1:0]     jobs_r;
    logic                  start_r;
    logic                  irq_r;
    logic                  err_r;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level_s  = wr_ptr_r - rd_ptr_r;
    assign empty_s  = (level_s == {QLVL_W{1'b0}});
    assign full_s   = (level_s == QLVL_W'(QDEPTH));
    assign head_s   = mem_r[rd_ptr_r[IDX_W-1:0]];

    // Ready depends only on registered state, so a full queue that is about to
    // pop still takes the offered job without a combinational input path.
    assign pop_ok_s = (state_r == ST_IDLE) && !empty_s;
    assign ready_s  = !full_s || pop_ok_s;
    assign push_s   = job_valid_i && ready_s && !abort_i;

    assign to_next_s = {1'b0, to_cnt_r} + {{TO_WIDTH{1'b0}}, 1'b1};
    assign to_hit_s  = (timeout_i != {TO_WIDTH{1'b0}}) && (to_next_s >= {1'b0, timeout_i});

    // Next-state and per-cycle action decode; abort overrides everything.
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        done_inc_s  = 1'b0;
        start_nxt_s = 1'b0;
        irq_nxt_s   = 1'b0;
        err_set_s   = 1'b0;
        to_clr_s    = 1'b0;
        to_inc_s    = 1'b0;
        if (abort_i) begin
            state_nxt_s = ST_IDLE;
            to_clr_s    = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!empty_s) begin
                        pop_s = 1'b1;
                        if (head_s != {CNT_BIT{1'b0}}) begin
                            state_nxt_s = ST_LAUNCH;
                        end else begin
                            done_inc_s = 1'b1;
                            irq_nxt_s  = (level_s == {{(QLVL_W-1){1'b0}}, 1'b1}) && !push_s;
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_LAUNCH: begin
                    if (acc_idle_i) begin
                        start_nxt_s = 1'b1;
                        to_clr_s    = 1'b1;
                        state_nxt_s = ST_WAIT;
                    end else begin
                        state_nxt_s = ST_LAUNCH;
                    end
                end
                ST_WAIT: begin
                    to_inc_s = 1'b1;
                    if (acc_done_i) begin
                        done_inc_s  = 1'b1;
                        irq_nxt_s   = empty_s && !push_s;
                        state_nxt_s = ST_GAP;
                    end else if (to_hit_s) begin
                        err_set_s   = 1'b1;
                        irq_nxt_s   = empty_s && !push_s;
                        state_nxt_s = ST_GAP;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end
                ST_GAP: begin
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state and registered accessor/interrupt pulses.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            start_r <= 1'b0;
            irq_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            start_r <= start_nxt_s;
            irq_r   <= irq_nxt_s;
        end
    end

    // Job FIFO storage and pointers; abort empties the queue.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_r <= {QLVL_W{1'b0}};
            rd_ptr_r <= {QLVL_W{1'b0}};
            for (int i = 0; i < QDEPTH; i++) begin
                mem_r[i] <= {CNT_BIT{1'b0}};
            end
        end else if (abort_i) begin
            wr_ptr_r <= {QLVL_W{1'b0}};
            rd_ptr_r <= {QLVL_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r[IDX_W-1:0]] <= job_count_i;
                wr_ptr_r <= wr_ptr_r + {{(QLVL_W-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(QLVL_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Run count register stays put from the pop until the next pop.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_r <= {CNT_BIT{1'b0}};
        end else if (pop_s) begin
            count_r <= head_s;
        end
    end

    // Completion counter, sticky timeout flag and WAIT timeout counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            jobs_r   <= {JOBS_W{1'b0}};
            err_r    <= 1'b0;
            to_cnt_r <= {TO_WIDTH{1'b0}};
        end else begin
            if (done_inc_s) begin
                jobs_r <= jobs_r + {{(JOBS_W-1){1'b0}}, 1'b1};
            end
            if (abort_i) begin
                err_r <= 1'b0;
            end else if (err_set_s) begin
                err_r <= 1'b1;
            end
            if (to_clr_s) begin
                to_cnt_r <= {TO_WIDTH{1'b0}};
            end else if (to_inc_s) begin
                to_cnt_r <= to_cnt_r + {{(TO_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    assign job_ready_o   = ready_s;
    assign acc_start_o   = start_r;
    assign acc_count_o   = count_r;
    assign busy_o        = (state_r != ST_IDLE) || !empty_s;
    assign q_level_o     = level_s;
    assign jobs_done_o   = jobs_r;
    assign err_timeout_o = err_r;
    assign irq_o         = irq_r;

endmodule
